// File: rtl/dmem_responder.sv
// Fixed-latency, single-outstanding data-memory slave with a word-addressed RAM.
// Flags misaligned and out-of-range accesses; responses are one-cycle registered pulses.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
    output logic        RspValid,
    output logic [31:0] RspRData,
    output logic        RspErr
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            wr_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic            rsp_valid_q;
    logic [31:0]     rsp_rdata_q;
    logic            rsp_err_q;

    logic [31:0]     mem [DEPTH_WORDS];

    logic            addr_err;
    logic [AW-1:0]   word_idx;
    logic            exec;

    // Anything above the top word is rejected rather than wrapped onto low memory.
    assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q[31:AW+2] != '0);
    assign word_idx = addr_q[AW+1:2];
    assign exec     = (state_q == BUSY) && (cnt_q == '0);

    assign ReqReady = (state_q == IDLE);
    assign RspValid = rsp_valid_q;
    assign RspRData = rsp_rdata_q;
    assign RspErr   = rsp_err_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ReqValid) begin
                        wr_q    <= ReqWrite;
                        addr_q  <= ReqAddr;
                        wdata_q <= ReqWData;
                        cnt_q   <= CW'(LATENCY - 1);
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= addr_err;
                        if (!addr_err && !wr_q)
                            rsp_rdata_q <= mem[word_idx];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Reset on the execute edge aborts the store.
    always_ff @(posedge Clk) begin
        if (!Reset && exec && wr_q && !addr_err)
            mem[word_idx] <= wdata_q;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder against a plain-array memory model.
// A second LATENCY=1 instance exercises back-to-back acceptance timing.
module tb_dmem_responder;
    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        ReqValid, ReqReady, ReqWrite;
    logic [31:0] ReqAddr, ReqWData;
    logic        RspValid, RspErr;
    logic [31:0] RspRData;

    logic        b_valid, b_ready, b_write;
    logic [31:0] b_addr, b_wdata;
    logic        b_rv, b_err;
    logic [31:0] b_rd;

    always #5 Clk = ~Clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqWrite(ReqWrite), .ReqAddr(ReqAddr), .ReqWData(ReqWData),
        .RspValid(RspValid), .RspRData(RspRData), .RspErr(RspErr)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u1 (
        .Clk(Clk), .Reset(Reset), .ReqValid(b_valid), .ReqReady(b_ready),
        .ReqWrite(b_write), .ReqAddr(b_addr), .ReqWData(b_wdata),
        .RspValid(b_rv), .RspRData(b_rd), .RspErr(b_err)
    );

    typedef struct {
        int unsigned cyc;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t        q[$];
    logic [31:0] model [DEPTH];
    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per response pulse; outputs must be zero otherwise.
    always @(negedge Clk) begin
        if (RspValid === 1'b1) begin
            if (q.size() == 0) begin
                chk(1'b0, "unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk(cyc == e.cyc, "rsp_cycle", cyc, e.cyc);
                chk(RspRData === e.rd, "rsp_rdata", RspRData, e.rd);
                chk(RspErr === e.err, "rsp_err", {31'd0, RspErr}, {31'd0, e.err});
            end
        end else begin
            chk(RspRData === 32'd0 && RspErr === 1'b0 && RspValid === 1'b0, "idle_outputs",
                RspRData, 32'd0);
        end
    end

    // Reference: error if misaligned or beyond the array; stores update the array, loads read it.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        bit   err;
        int   n = 0;
        ReqValid = 1'b1; ReqWrite = w; ReqAddr = a; ReqWData = d;
        while (ReqReady !== 1'b1 && n < 50) begin
            @(negedge Clk);
            n++;
        end
        if (ReqReady !== 1'b1) begin
            chk(1'b0, "accept_timeout", 32'd0, 32'd1);
            ReqValid = 1'b0;
            return;
        end
        err   = (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
        e.cyc = cyc + 1 + LAT;
        e.err = err;
        e.rd  = (err || w) ? 32'd0 : model[a / 4];
        if (!err && w) model[a / 4] = d;
        q.push_back(e);
        @(negedge Clk);
        for (int k = 0; k < LAT; k++) begin
            chk(ReqReady === 1'b0, "busy_ready", {31'd0, ReqReady}, 32'd0);
            // Garbage while busy must be ignored.
            ReqValid = 1'($urandom_range(0, 1));
            ReqWrite = 1'($urandom_range(0, 1));
            ReqAddr  = $urandom;
            ReqWData = $urandom;
            @(negedge Clk);
        end
        ReqValid = 1'b0;
        chk(ReqReady === 1'b1, "ready_after_rsp", {31'd0, ReqReady}, 32'd1);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 5) return {22'd0, 8'($urandom_range(0, DEPTH - 1)), 2'b00};
        if (r == 6) return {22'd0, 8'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
        if (r == 7) return 32'h400 + ($urandom & 32'h0FFF_FFFF);
        if (r == 8) return 32'h3FC;
        return ($urandom_range(0, 1) == 1) ? 32'h400 : 32'hFFFF_FFFC;
    endfunction

    initial begin
        Reset = 1'b1;
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 32'h0; ReqWData = 32'h1111_1111;
        b_valid = 1'b0; b_write = 1'b0; b_addr = 32'h40; b_wdata = 32'h0;

        // Reset held with a request presented: never accepted.
        repeat (3) begin
            @(negedge Clk);
            chk(ReqReady === 1'b1, "reset_ready", {31'd0, ReqReady}, 32'd1);
        end
        Reset = 1'b0; ReqValid = 1'b0;
        @(negedge Clk);
        chk(ReqReady === 1'b1 && RspValid === 1'b0 && RspRData === 32'd0 && RspErr === 1'b0,
            "post_reset", {31'd0, ReqReady}, 32'd1);

        // Fill every word so later loads have known contents.
        for (int i = 0; i < DEPTH; i++) do_req(1'b1, 32'(i * 4), $urandom);

        do_req(1'b1, 32'h10, 32'hDEAD_BEEF);
        do_req(1'b0, 32'h10, 32'h0);
        do_req(1'b1, 32'h13, 32'h1234_5678);
        do_req(1'b0, 32'h10, 32'h0);
        do_req(1'b0, 32'h400, 32'h0);
        do_req(1'b1, 32'h3FC, 32'hA5A5_A5A5);
        do_req(1'b0, 32'h3FC, 32'h0);
        do_req(1'b0, 32'h000, 32'h0);

        // Store aborted by reset one edge after acceptance: no pulse, no write.
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 32'h20; ReqWData = 32'hCAFE_F00D;
        @(negedge Clk);
        chk(ReqReady === 1'b0, "abort_accepted", {31'd0, ReqReady}, 32'd0);
        ReqValid = 1'b0; Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk(ReqReady === 1'b1, "abort_ready", {31'd0, ReqReady}, 32'd1);
        repeat (3) @(negedge Clk);
        do_req(1'b0, 32'h20, 32'h0);

        // LATENCY=1 instance with valid held high: accept every other edge.
        b_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge Clk);
            chk(b_ready === 1'((k % 2) == 0), "b2b_ready", {31'd0, b_ready}, 32'((k % 2) == 0));
            chk(b_rv === 1'((k % 2) == 0), "b2b_rspvalid", {31'd0, b_rv}, 32'((k % 2) == 0));
            if (k % 2 == 0) chk(b_err === 1'b0, "b2b_err", {31'd0, b_err}, 32'd0);
        end
        b_valid = 1'b0;
        @(negedge Clk);
        chk(b_rv === 1'b0 && b_ready === 1'b1, "b2b_tail", {31'd0, b_rv}, 32'd0);

        // Randomized mix with idle gaps.
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge Clk);
            do_req(1'($urandom_range(0, 1)), rand_addr(), $urandom);
        end

        for (int n = 0; n < 20 && q.size() != 0; n++) @(negedge Clk);
        chk(q.size() == 0, "drain", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
